// File: rtl/line_buf_pkg.sv
// Shared types, default sizes and width helper
// for the multi-line window buffer.
package line_buf_pkg;

  localparam int DATA_W_D    = 8;
  localparam int LINE_LEN_D  = 480;
  localparam int WIN_W_D     = 6;
  localparam int WIN_H_D     = 3;
  localparam int NUM_LINES_D = 4;

  typedef logic [DATA_W_D-1:0] pixel_t;

  // Pointer width able to index n entries (at least 1 bit).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_store.sv
// One image line of storage with a write port and
// WIN_W combinational read taps starting at a base column.
module line_store
  import line_buf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int LINE_LEN = LINE_LEN_D,
  parameter int WIN_W    = WIN_W_D
) (
  input  logic                        i_clk,
  input  logic                        i_we,
  input  logic [ptr_w(LINE_LEN)-1:0]  i_wr_col,
  input  logic [DATA_W-1:0]           i_wr_data,
  input  logic [ptr_w(LINE_LEN)-1:0]  i_rd_col,
  output logic [WIN_W*DATA_W-1:0]     o_taps
);

  localparam int CW = ptr_w(LINE_LEN);

  logic [DATA_W-1:0] mem [LINE_LEN];

  // Pixel storage is intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_wr_col] <= i_wr_data;
  end

  for (genvar c = 0; c < WIN_W; c++) begin : g_tap
    assign o_taps[c*DATA_W +: DATA_W] =
      mem[i_rd_col + CW'(c)];
  end

endmodule

// File: rtl/line_window_buffer.sv
// Ring of NUM_LINES lines presenting a WIN_H x WIN_W
// window, with input back-pressure and line release.
module line_window_buffer
  import line_buf_pkg::*;
#(
  parameter int DATA_W    = DATA_W_D,
  parameter int LINE_LEN  = LINE_LEN_D,
  parameter int WIN_W     = WIN_W_D,
  parameter int WIN_H     = WIN_H_D,
  parameter int NUM_LINES = NUM_LINES_D
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [DATA_W-1:0]                 i_data,
  input  logic                              i_data_valid,
  output logic                              o_data_ready,
  output logic [WIN_H*WIN_W*DATA_W-1:0]     o_win,
  output logic                              o_win_valid,
  input  logic                              i_win_ready,
  output logic [ptr_w(NUM_LINES+1)-1:0]     o_line_cnt,
  output logic [ptr_w(LINE_LEN)-1:0]        o_col
);

  localparam int LW = ptr_w(NUM_LINES);
  localparam int CW = ptr_w(LINE_LEN);
  localparam int NW = ptr_w(NUM_LINES+1);
  localparam int RW = WIN_W*DATA_W;

  logic [LW-1:0] wr_line_q, wr_line_d;
  logic [LW-1:0] rd_line_q, rd_line_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          wr_fire, rd_fire;
  logic          wr_eol, rd_eol;
  logic [RW-1:0] taps [NUM_LINES];

  assign o_data_ready = cnt_q < NW'(NUM_LINES);
  assign o_win_valid  = cnt_q >= NW'(WIN_H);
  assign o_line_cnt   = cnt_q;
  assign o_col        = rd_col_q;

  assign wr_fire = i_data_valid && o_data_ready;
  assign rd_fire = o_win_valid && i_win_ready;
  assign wr_eol  = wr_fire &&
                   (wr_col_q == CW'(LINE_LEN-1));
  assign rd_eol  = rd_fire &&
                   (rd_col_q == CW'(LINE_LEN-WIN_W));

  always_comb begin
    wr_line_d = wr_line_q;
    wr_col_d  = wr_col_q;
    rd_line_d = rd_line_q;
    rd_col_d  = rd_col_q;
    cnt_d     = cnt_q;
    if (wr_fire) begin
      if (wr_eol) begin
        wr_col_d  = '0;
        wr_line_d = (wr_line_q == LW'(NUM_LINES-1)) ?
                    '0 : wr_line_q + LW'(1);
      end else begin
        wr_col_d = wr_col_q + CW'(1);
      end
    end
    if (rd_fire) begin
      if (rd_eol) begin
        rd_col_d  = '0;
        rd_line_d = (rd_line_q == LW'(NUM_LINES-1)) ?
                    '0 : rd_line_q + LW'(1);
      end else begin
        rd_col_d = rd_col_q + CW'(1);
      end
    end
    // Completion and release on one edge cancel out.
    unique case (1'b1)
      wr_eol && !rd_eol: cnt_d = cnt_q + NW'(1);
      rd_eol && !wr_eol: cnt_d = cnt_q - NW'(1);
      default:           cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_line_q <= '0;
      wr_col_q  <= '0;
      rd_line_q <= '0;
      rd_col_q  <= '0;
      cnt_q     <= '0;
    end else begin
      wr_line_q <= wr_line_d;
      wr_col_q  <= wr_col_d;
      rd_line_q <= rd_line_d;
      rd_col_q  <= rd_col_d;
      cnt_q     <= cnt_d;
    end
  end

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    line_store #(
      .DATA_W  (DATA_W),
      .LINE_LEN(LINE_LEN),
      .WIN_W   (WIN_W)
    ) u_line (
      .i_clk    (i_clk),
      .i_we     (wr_fire && (wr_line_q == LW'(l))),
      .i_wr_col (wr_col_q),
      .i_wr_data(i_data),
      .i_rd_col (rd_col_q),
      .o_taps   (taps[l])
    );
  end

  for (genvar r = 0; r < WIN_H; r++) begin : g_row
    logic [LW:0]   sum;
    logic [LW-1:0] sel;
    assign sum = {1'b0, rd_line_q} + (LW+1)'(r);
    assign sel = (sum >= (LW+1)'(NUM_LINES)) ?
                 LW'(sum - (LW+1)'(NUM_LINES)) :
                 sum[LW-1:0];
    assign o_win[r*RW +: RW] = taps[sel];
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer against
// a line/window-count reference model.
module tb_line_window_buffer;

  localparam int DW  = 8;
  localparam int LL  = 8;
  localparam int WW  = 3;
  localparam int WH  = 3;
  localparam int NL  = 4;
  localparam int WPL = LL - WW + 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [DW-1:0] i_data;
  logic          i_data_valid;
  logic          o_data_ready;
  logic [71:0]   o_win;
  logic          o_win_valid;
  logic          i_win_ready;
  logic [2:0]    o_line_cnt;
  logic [2:0]    o_col;

  int n_chk = 0;
  int n_fail = 0;
  int m_wr;
  int m_rd;
  logic [7:0] pix [64][LL];

  line_window_buffer #(
    .DATA_W(DW), .LINE_LEN(LL), .WIN_W(WW),
    .WIN_H(WH), .NUM_LINES(NL)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_data),
    .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready),
    .o_win       (o_win),
    .o_win_valid (o_win_valid),
    .i_win_ready (i_win_ready),
    .o_line_cnt  (o_line_cnt),
    .o_col       (o_col)
  );

  always #5 i_clk = ~i_clk;

  // Complete lines written minus lines fully consumed.
  function automatic int m_cnt();
    return m_wr / LL - m_rd / WPL;
  endfunction

  function automatic logic [71:0] m_win();
    int rel;
    int col;
    logic [71:0] w;
    rel = m_rd / WPL;
    col = m_rd % WPL;
    w = '0;
    for (int r = 0; r < WH; r++)
      for (int c = 0; c < WW; c++)
        w[(r*WW+c)*DW +: DW] = pix[(rel+r)%64][col+c];
    return w;
  endfunction

  task automatic step(input logic dv,
                      input logic [7:0] d,
                      input logic wr);
    logic fw;
    logic fr;
    i_data_valid = dv;
    i_data = d;
    i_win_ready = wr;
    fw = dv && (m_cnt() < NL);
    fr = wr && (m_cnt() >= WH);
    @(posedge i_clk);
    if (fw) begin
      pix[(m_wr/LL)%64][m_wr%LL] = d;
      m_wr++;
    end
    if (fr) m_rd++;
    #1;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    i_data_valid = 1'b0;
    i_win_ready = 1'b0;
    i_data = '0;
    #1;
    m_wr = 0;
    m_rd = 0;
    n_chk++;
    if (o_data_ready !== 1'b1 || o_win_valid !== 1'b0 ||
        o_line_cnt !== 3'd0 || o_col !== 3'd0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b cnt=%0d col=%0d need 1 0 0 0",
               o_data_ready, o_win_valid, o_line_cnt, o_col);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_fill(input string nm);
    logic [71:0] e;
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < LL; c++) begin
        step(1'b1, 8'(16*l+c), 1'b0);
        n_chk++;
        if (o_win_valid !== (l == 2 && c == 7)) begin
          n_fail++;
          $display("FAIL %s_valid l%0d c%0d: got %b need %b",
                   nm, l, c, o_win_valid, (l == 2 && c == 7));
        end
      end
    i_data_valid = 1'b0;
    e = '0;
    for (int r = 0; r < WH; r++)
      for (int c = 0; c < WW; c++)
        e[(r*WW+c)*DW +: DW] = 8'(16*r+c);
    n_chk++;
    if (o_win !== e) begin
      n_fail++;
      $display("FAIL %s_win: got %h need %h", nm, o_win, e);
    end
    n_chk++;
    if (o_line_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL %s_cnt: got %0d need 3", nm, o_line_cnt);
    end
  endtask

  task automatic test_drain;
    for (int i = 0; i < WPL; i++) begin
      n_chk++;
      if (o_col !== 3'(i) || o_win !== m_win()) begin
        n_fail++;
        $display("FAIL drain_%0d: col=%0d win=%h need col=%0d win=%h",
                 i, o_col, o_win, i, m_win());
      end
      if (i == WPL-1) begin
        n_chk++;
        if (o_win[23:0] !== 24'h070605) begin
          n_fail++;
          $display("FAIL drain_last_row0: got %h need 070605",
                   o_win[23:0]);
        end
      end
      step(1'b0, 8'h00, 1'b1);
    end
    i_win_ready = 1'b0;
    n_chk++;
    if (o_line_cnt !== 3'd2 || o_win_valid !== 1'b0 ||
        o_col !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_end: cnt=%0d vld=%b col=%0d need 2 0 0",
               o_line_cnt, o_win_valid, o_col);
    end
  endtask

  task automatic test_backpressure;
    test_reset();
    for (int l = 0; l < NL; l++)
      for (int c = 0; c < LL; c++) begin
        step(1'b1, 8'(16*l+c), 1'b0);
        n_chk++;
        if (o_data_ready !== !(l == 3 && c == 7)) begin
          n_fail++;
          $display("FAIL bp_ready l%0d c%0d: got %b",
                   l, c, o_data_ready);
        end
      end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hFF, 1'b0);
      n_chk++;
      if (o_data_ready !== 1'b0 || o_line_cnt !== 3'd4) begin
        n_fail++;
        $display("FAIL bp_extra_%0d: rdy=%b cnt=%0d need 0 4",
                 i, o_data_ready, o_line_cnt);
      end
    end
    for (int i = 0; i < WPL; i++) begin
      n_chk++;
      if (o_win !== m_win()) begin
        n_fail++;
        $display("FAIL bp_win_%0d: got %h need %h",
                 i, o_win, m_win());
      end
      step(1'b0, 8'h00, 1'b1);
      n_chk++;
      if (o_data_ready !== (i == WPL-1)) begin
        n_fail++;
        $display("FAIL bp_release_%0d: rdy=%b need %b",
                 i, o_data_ready, (i == WPL-1));
      end
    end
    i_win_ready = 1'b0;
  endtask

  task automatic test_simul;
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h41, 1'b0);
    for (int i = 0; i < WPL; i++) begin
      step(1'b1, 8'(8'h42 + i), 1'b1);
      n_chk++;
      if (o_line_cnt !== 3'd3 || o_win_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL simul_%0d: cnt=%0d vld=%b need 3 1",
                 i, o_line_cnt, o_win_valid);
      end
    end
    i_data_valid = 1'b0;
    i_win_ready = 1'b0;
    n_chk++;
    if (o_win[55:48] !== 8'h40 || o_win !== m_win() ||
        o_col !== 3'd0) begin
      n_fail++;
      $display("FAIL simul_wrap: win=%h col=%0d need %h col 0",
               o_win, o_col, m_win());
    end
  endtask

  task automatic test_random;
    int cyc;
    test_reset();
    cyc = 0;
    while (m_wr < 10*LL && cyc < 3000) begin
      step($urandom_range(0, 9) < 7, 8'($urandom),
           $urandom_range(0, 9) < 6);
      cyc++;
      n_chk++;
      if (o_data_ready !== (m_cnt() < NL) ||
          o_win_valid !== (m_cnt() >= WH) ||
          o_line_cnt !== 3'(m_cnt()) ||
          o_col !== 3'(m_rd % WPL)) begin
        n_fail++;
        $display("FAIL rand_ctl cyc%0d: rdy=%b vld=%b cnt=%0d col=%0d need cnt=%0d col=%0d",
                 cyc, o_data_ready, o_win_valid, o_line_cnt,
                 o_col, m_cnt(), m_rd % WPL);
      end
      if (m_cnt() >= WH) begin
        n_chk++;
        if (o_win !== m_win()) begin
          n_fail++;
          $display("FAIL rand_win cyc%0d: got %h need %h",
                   cyc, o_win, m_win());
        end
      end
    end
    n_chk++;
    if (m_wr < 10*LL) begin
      n_fail++;
      $display("FAIL rand_timeout: pixels=%0d need %0d",
               m_wr, 10*LL);
    end
    i_data_valid = 1'b0;
    i_win_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    test_reset();
    for (int k = 0; k < 2*LL+5; k++)
      step(1'b1, 8'(16*(k/LL) + k%LL), 1'b0);
    n_chk++;
    if (o_line_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_cnt: got %0d need 2", o_line_cnt);
    end
    i_rst_n = 1'b0;
    i_data_valid = 1'b0;
    #1;
    m_wr = 0;
    m_rd = 0;
    n_chk++;
    if (o_data_ready !== 1'b1 || o_win_valid !== 1'b0 ||
        o_line_cnt !== 3'd0 || o_col !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset: rdy=%b vld=%b cnt=%0d col=%0d need 1 0 0 0",
               o_data_ready, o_win_valid, o_line_cnt, o_col);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    test_fill("refill");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill("fill");
    test_drain();
    test_backpressure();
    test_simul();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
